// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction-fetch sequencer
package fetch_pkg;
  typedef enum logic [1:0] {RUN, HALT, FAULT} fetch_state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  localparam int Q_DEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry registered FIFO of {pc, instr} with push/pop/flush; head is entry 0
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);
  fetch_entry_t e1;
  always_ff @(posedge clk) begin
    if (rst || flush) count <= 2'd0;
    else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      // entry 0 only refills when it is empty or consumed; stale writes to empty slots are harmless
      if (pop || count == 2'd0) head <= (pop && count == 2'd2) ? e1 : din;
      if (push) e1 <= din;
    end
  end
endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: PC/FSM sequencer feeding IF/ID through a 2-entry prefetch queue.
// Optional FETCH_FAULT_EN adds a FAULT state for misaligned targets and out-of-range fetches.
module imem_fetch_ctrl #(
`ifdef FETCH_FAULT_EN
  parameter int IMEM_DEPTH = 32,
`endif
  parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC,
  parameter int Q_DEPTH = fetch_pkg::Q_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  input  logic        resume_req,
  input  logic [31:0] resume_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        halted,
  output logic        fetch_fault
);
  import fetch_pkg::*;
  fetch_state_e state, state_n;
  logic [31:0] pc, pc_n;
  logic push, pop;
  logic [1:0] count;
  fetch_entry_t head;
`ifdef FETCH_FAULT_EN
  localparam logic [31:0] PC_LIMIT = 32'(IMEM_DEPTH * 4);
`else
  logic unused_low_bits;
  assign unused_low_bits = ^{redirect_pc[1:0], resume_pc[1:0]};
`endif
  assign pop = if_valid && if_ready;
  always_comb begin
    state_n = state;
    pc_n = pc;
    push = 1'b0;
    if (redirect_valid) begin
      pc_n = {redirect_pc[31:2], 2'b00};
      state_n = (state == RUN && halt_req) ? HALT : (state == FAULT ? RUN : state);
`ifdef FETCH_FAULT_EN
      if (redirect_pc[1:0] != 2'b00) state_n = FAULT;
`endif
    end else if (state == RUN && halt_req) state_n = HALT;
    else if (state == HALT && resume_req) begin
      pc_n = {resume_pc[31:2], 2'b00};
      state_n = RUN;
`ifdef FETCH_FAULT_EN
      if (resume_pc[1:0] != 2'b00) state_n = FAULT;
`endif
    end else if (state == RUN && (count != 2'(Q_DEPTH) || pop)) begin
`ifdef FETCH_FAULT_EN
      if (pc >= PC_LIMIT) state_n = FAULT;
      else
`endif
      begin
        push = 1'b1;
        pc_n = pc + 32'd4;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc <= RESET_PC;
    end else begin
      state <= state_n;
      pc <= pc_n;
    end
  end
  fetch_queue u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   ('{pc: pc, instr: imem_instr}),
    .head  (head),
    .count (count)
  );
  assign imem_addr = pc;
  assign if_valid = count != 2'd0;
  assign if_pc = if_valid ? head.pc : 32'd0;
  assign if_instr = if_valid ? head.instr : 32'd0;
  assign if_pc_plus4 = if_valid ? head.pc + 32'd4 : 32'd0;
  assign halted = state == HALT && !if_valid;
`ifdef FETCH_FAULT_EN
  assign fetch_fault = state == FAULT;
`else
  assign fetch_fault = 1'b0;
`endif
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed scenarios plus random traffic checked against a queue-based fetch model
module tb_imem_fetch_ctrl;
  logic clk = 1'b0;
  logic rst, redirect_valid, halt_req, resume_req, if_ready;
  logic [31:0] imem_addr, imem_instr, redirect_pc, resume_pc;
  logic if_valid, halted, fetch_fault;
  logic [31:0] if_instr, if_pc, if_pc_plus4;
  int checks = 0, failures = 0;
  localparam int M_RUN = 0, M_HALT = 1, M_FAULT = 2;
  logic [31:0] mq[$];
  logic [31:0] mpc;
  int ms;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction
  assign imem_instr = imem(imem_addr);

  imem_fetch_ctrl dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .resume_req(resume_req), .resume_pc(resume_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .halted(halted), .fetch_fault(fetch_fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit bad_target(input logic [31:0] t);
`ifdef FETCH_FAULT_EN
    return t[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit out_of_range(input logic [31:0] a);
`ifdef FETCH_FAULT_EN
    return a >= 32'd128;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_update();
    bit pop;
    pop = mq.size() != 0 && if_ready;
    if (rst) begin
      mq.delete();
      mpc = 32'h0;
      ms = M_RUN;
    end else if (redirect_valid) begin
      mq.delete();
      mpc = redirect_pc & ~32'd3;
      if (ms == M_FAULT) ms = M_RUN;
      else if (ms == M_RUN && halt_req) ms = M_HALT;
      if (bad_target(redirect_pc)) ms = M_FAULT;
    end else begin
      if (pop) void'(mq.pop_front());
      if (ms == M_RUN && halt_req) ms = M_HALT;
      else if (ms == M_HALT && resume_req) begin
        mpc = resume_pc & ~32'd3;
        ms = bad_target(resume_pc) ? M_FAULT : M_RUN;
      end else if (ms == M_RUN && mq.size() < 2) begin
        if (out_of_range(mpc)) ms = M_FAULT;
        else begin
          mq.push_back(mpc);
          mpc = mpc + 32'd4;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic rv, input logic [31:0] rpc,
                      input logic hr, input logic rr, input logic [31:0] spc, input logic rdy);
    bit v;
    @(negedge clk);
    rst = r; redirect_valid = rv; redirect_pc = rpc;
    halt_req = hr; resume_req = rr; resume_pc = spc; if_ready = rdy;
    #1;
    v = mq.size() != 0;
    check("if_valid", {31'd0, if_valid}, {31'd0, v});
    check("if_pc", if_pc, v ? mq[0] : 32'd0);
    check("if_instr", if_instr, v ? imem(mq[0]) : 32'd0);
    check("if_pc_plus4", if_pc_plus4, v ? mq[0] + 32'd4 : 32'd0);
    check("imem_addr", imem_addr, mpc);
    check("halted", {31'd0, halted}, {31'd0, ms == M_HALT && !v});
    check("fetch_fault", {31'd0, fetch_fault}, {31'd0, ms == M_FAULT});
    model_update();
  endtask

  task automatic run_ready(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, rdy);
  endtask

  initial begin
    rst = 1; redirect_valid = 0; redirect_pc = 0; halt_req = 0;
    resume_req = 0; resume_pc = 0; if_ready = 1;
    repeat (2) @(posedge clk);
    mq.delete(); mpc = 32'h0; ms = M_RUN;
    step(1, 0, 0, 0, 0, 0, 1);
    run_ready(6, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    run_ready(1, 1);
    run_ready(3, 0);
    run_ready(5, 1);
    run_ready(3, 0);
    step(0, 1, 32'h40, 0, 0, 0, 1);
    run_ready(4, 1);
    step(0, 1, 32'h10, 0, 0, 0, 0);
    run_ready(3, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    run_ready(4, 1);
    step(0, 0, 0, 0, 1, 32'h20, 1);
    run_ready(4, 1);
    step(0, 1, 32'h80, 1, 0, 0, 1);
    run_ready(3, 1);
    step(0, 0, 0, 0, 1, 32'h60, 1);
    run_ready(4, 1);
    step(0, 1, 32'h42, 0, 0, 0, 1);
    run_ready(3, 1);
    step(0, 1, 32'h0, 0, 0, 0, 1);
    run_ready(4, 1);
    step(0, 1, 32'hFFFF_FFF8, 0, 0, 0, 1);
    run_ready(4, 1);
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] t1, t2;
      t1 = {$urandom_range(0, 40), 2'b00} | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      t2 = {$urandom_range(0, 40), 2'b00} | (($urandom_range(0, 5) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0, t1,
           $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, t2,
           $urandom_range(0, 9) < 7);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
